// File: rtl/imem_loader_pkg.sv
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction-memory
//                byte-stream loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

  // Loader control states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } loader_state_t;

  // Bytes assembled into one instruction word (MSB first)
  localparam int BYTES_PER_WORD = 4;

endpackage : imem_loader_pkg

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
//  Module      : imem_loader
//  Description : Accepts a framed byte stream (16-bit word count, 4 bytes per
//                word MSB-first, XOR checksum byte), writes the assembled
//                32-bit words into the instruction memory at addresses 0..N-1,
//                stalls the processor during the load and reports done/err.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Largest legal word count; 17 bits so 2^16 is representable
  localparam logic [16:0] c_MAX_LEN = 17'd1 << ADDR_W;
  localparam logic [1:0]  c_LAST_IDX = 2'(BYTES_PER_WORD - 1);

  loader_state_t     r_state;
  logic [7:0]        r_len_hi;
  logic [16:0]       r_remain;
  logic [1:0]        r_idx;
  logic [23:0]       r_shift;
  logic [7:0]        r_xor;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_err;

  logic              w_active;
  logic              w_accept;
  logic [15:0]       w_len;
  logic [31:0]       w_word;

  // Stream-consuming states; ready depends on the state register only
  assign w_active = (r_state == LEN_HI) || (r_state == LEN_LO) ||
                    (r_state == DATA)   || (r_state == CSUM);
  assign w_accept = in_valid && w_active;
  assign w_len    = {r_len_hi, in_data};
  assign w_word   = {r_shift, in_data};

  // Frame parser, word assembler, write issue and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_len_hi   <= 8'd0;
      r_remain   <= 17'd0;
      r_idx      <= 2'd0;
      r_shift    <= 24'd0;
      r_xor      <= 8'd0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 32'd0;
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      // Address advances in the cycle after each write; wraps naturally
      if (r_wr_en) begin
        r_wr_addr <= r_wr_addr + ADDR_W'(1);
      end

      case (r_state)
        IDLE, DONE, ERR: begin
          if (start) begin
            r_state    <= LEN_HI;
            r_xor      <= 8'd0;
            r_idx      <= 2'd0;
            r_wr_addr  <= '0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
          end
        end

        LEN_HI: begin
          if (w_accept) begin
            r_len_hi <= in_data;
            r_xor    <= r_xor ^ in_data;
            r_state  <= LEN_LO;
          end
        end

        LEN_LO: begin
          if (w_accept) begin
            r_xor <= r_xor ^ in_data;
            if ({1'b0, w_len} > c_MAX_LEN) begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end else if (w_len == 16'd0) begin
              r_state <= CSUM;
            end else begin
              r_state  <= DATA;
              r_remain <= {1'b0, w_len};
              r_idx    <= 2'd0;
            end
          end
        end

        DATA: begin
          if (w_accept) begin
            r_xor   <= r_xor ^ in_data;
            r_shift <= w_word[23:0];
            r_idx   <= r_idx + 2'd1;
            if (r_idx == c_LAST_IDX) begin
              r_wr_en   <= 1'b1;
              r_wr_data <= w_word;
              r_remain  <= r_remain - 17'd1;
              if (r_remain == 17'd1) begin
                r_state <= CSUM;
              end
            end
          end
        end

        CSUM: begin
          if (w_accept) begin
            if (in_data == r_xor) begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              // Processor stays held: the image in memory is invalid
              r_state <= ERR;
              r_err   <= 1'b1;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready = w_active;
  assign busy     = w_active;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign cpu_hold = r_cpu_hold;
  assign done     = r_done;
  assign err      = r_err;

endmodule : imem_loader

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader (ADDR_W = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  int total;
  int bad;

  // Captured writes
  logic [ADDR_W-1:0] cap_addr [64];
  logic [31:0]       cap_data [64];
  int                wr_n;

  // Normal frame: len=2, two words, checksum slot at index 10.
  // XOR of 00 02 AC 41 00 00 8C 85 00 00 = 0xE6
  logic [7:0] frame [11];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe, sampled away from the rising edge
  always @(negedge clk) begin
    if (wr_en) begin
      cap_addr[wr_n % 64] <= wr_addr;
      cap_data[wr_n % 64] <= wr_data;
      wr_n                <= wr_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; optional idle gap, then hold the byte until taken
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_range(input int lo, input int hi, input int maxgap);
    for (int i = lo; i <= hi; i++) begin
      send_byte(frame[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_two_writes(input string tag, input int base);
    #1;
    chk({tag, "_nwr"},   32'(wr_n - base), 32'd2);
    chk({tag, "_a0"},    32'(cap_addr[base % 64]), 32'd0);
    chk({tag, "_d0"},    cap_data[base % 64], 32'hAC41_0000);
    chk({tag, "_a1"},    32'(cap_addr[(base + 1) % 64]), 32'd1);
    chk({tag, "_d1"},    cap_data[(base + 1) % 64], 32'h8C85_0000);
  endtask

  initial begin
    int base;
    total    = 0;
    bad      = 0;
    wr_n     = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    frame    = '{8'h00, 8'h02, 8'hAC, 8'h41, 8'h00, 8'h00,
                 8'h8C, 8'h85, 8'h00, 8'h00, 8'hE6};

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_wren",  32'(wr_en),    32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_done",  32'(done),     32'd0);
    chk("rst_err",   32'(err),      32'd0);
    chk("rst_hold",  32'(cpu_hold), 32'd0);
    chk("rst_addr",  32'(wr_addr),  32'd0);
    chk("rst_data",  wr_data,       32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- normal load, full rate ----------------
    base = wr_n;
    pulse_start();
    chk("st_hold",  32'(cpu_hold), 32'd1);
    chk("st_busy",  32'(busy),     32'd1);
    chk("st_ready", 32'(in_ready), 32'd1);
    send_range(0, 10, 0);
    check_two_writes("norm", base);
    chk("norm_done", 32'(done),     32'd1);
    chk("norm_err",  32'(err),      32'd0);
    chk("norm_hold", 32'(cpu_hold), 32'd0);
    chk("norm_busy", 32'(busy),     32'd0);
    chk("norm_addr", 32'(wr_addr),  32'd2);

    // ---------------- bad checksum ----------------
    frame[10] = 8'h65;
    base = wr_n;
    pulse_start();
    chk("bad_done_clr", 32'(done), 32'd0);
    send_range(0, 10, 0);
    check_two_writes("bad", base);
    chk("bad_err",  32'(err),      32'd1);
    chk("bad_done", 32'(done),     32'd0);
    chk("bad_hold", 32'(cpu_hold), 32'd1);
    chk("bad_busy", 32'(busy),     32'd0);

    // ---------------- length overflow (257 words) ----------------
    base = wr_n;
    pulse_start();
    chk("ovf_err_clr", 32'(err), 32'd0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    chk("ovf_err",   32'(err),      32'd1);
    chk("ovf_ready", 32'(in_ready), 32'd0);
    chk("ovf_hold",  32'(cpu_hold), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("ovf_nwr",   32'(wr_n - base), 32'd0);
    chk("ovf_err2",  32'(err), 32'd1);

    // ---------------- zero length ----------------
    @(negedge clk);
    base = wr_n;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    #1;
    chk("zero_done", 32'(done),        32'd1);
    chk("zero_err",  32'(err),         32'd0);
    chk("zero_nwr",  32'(wr_n - base), 32'd0);
    chk("zero_hold", 32'(cpu_hold),    32'd0);

    // ---------------- back-pressure / idle input ----------------
    @(negedge clk);
    frame[10] = 8'hE6;
    base = wr_n;
    pulse_start();
    send_range(0, 10, 3);
    check_two_writes("bp", base);
    chk("bp_done", 32'(done), 32'd1);

    // ---------------- reset mid-load ----------------
    @(negedge clk);
    pulse_start();
    send_range(0, 5, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_ready", 32'(in_ready), 32'd0);
    chk("mid_wren",  32'(wr_en),    32'd0);
    chk("mid_busy",  32'(busy),     32'd0);
    chk("mid_hold",  32'(cpu_hold), 32'd0);
    chk("mid_addr",  32'(wr_addr),  32'd0);
    chk("mid_data",  wr_data,       32'd0);
    chk("mid_done",  32'(done),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- reload, with start pulsed mid-DATA ----------------
    base = wr_n;
    pulse_start();
    send_range(0, 2, 0);
    pulse_start();
    chk("ign_busy",  32'(busy),     32'd1);
    chk("ign_ready", 32'(in_ready), 32'd1);
    send_range(3, 10, 0);
    check_two_writes("rl", base);
    chk("rl_done", 32'(done), 32'd1);
    chk("rl_err",  32'(err),  32'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard ceiling on simulation length
  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule : tb_imem_loader

`default_nettype wire
